// File: rtl/r_arbiter_if.sv
// R-channel bundle between the three read sources, the arbiter and the R decoder.
// ARB_TIMEOUT exists only when R_ARB_WATCHDOG_EN is defined.
interface r_arbiter_if #(
  parameter int ID_BITS   = 8,
  parameter int DATA_BITS = 32
);
  // Handshake: a beat moves on a rising clk edge where the granted RVALID_Sx and RREADY_Sx are both 1; a source holds its beat stable until then.
  logic [ID_BITS-1:0]   RID_S0, RID_S1, RID_S2;
  logic [DATA_BITS-1:0] RDATA_S0, RDATA_S1, RDATA_S2;
  logic [1:0]           RRESP_S0, RRESP_S1, RRESP_S2;
  logic                 RLAST_S0, RLAST_S1, RLAST_S2;
  logic                 RVALID_S0, RVALID_S1, RVALID_S2;
  logic                 RREADY_S0, RREADY_S1, RREADY_S2;

  logic [1:0]           SlaveID;
  logic [ID_BITS-1:0]   RID;
  logic [DATA_BITS-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
`ifdef R_ARB_WATCHDOG_EN
  logic                 ARB_TIMEOUT;
`endif

  modport slave (
    input  RID_S0, RID_S1, RID_S2, RDATA_S0, RDATA_S1, RDATA_S2,
    input  RRESP_S0, RRESP_S1, RRESP_S2, RLAST_S0, RLAST_S1, RLAST_S2,
    input  RVALID_S0, RVALID_S1, RVALID_S2, RREADY_S0, RREADY_S1, RREADY_S2,
    output SlaveID, RID, RDATA, RRESP, RLAST, RVALID
`ifdef R_ARB_WATCHDOG_EN
    , output ARB_TIMEOUT
`endif
  );

  modport master (
    output RID_S0, RID_S1, RID_S2, RDATA_S0, RDATA_S1, RDATA_S2,
    output RRESP_S0, RRESP_S1, RRESP_S2, RLAST_S0, RLAST_S1, RLAST_S2,
    output RVALID_S0, RVALID_S1, RVALID_S2, RREADY_S0, RREADY_S1, RREADY_S2,
    input  SlaveID, RID, RDATA, RRESP, RLAST, RVALID
`ifdef R_ARB_WATCHDOG_EN
    , input ARB_TIMEOUT
`endif
  );
endinterface

// File: rtl/r_arbiter.sv
// R-channel arbiter: locks onto S0/S1/S2 for a whole burst, round-robin between bursts.
// Define R_ARB_WATCHDOG_EN to add the stall watchdog and its ARB_TIMEOUT pulse.
module r_arbiter #(
  parameter int ID_BITS        = 8,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  r_arbiter_if.slave bus,
  output logic       dbg_busy,
  output logic [1:0] dbg_rr_ptr
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [1:0] NONE = 2'd3;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t               state, state_d;
  logic [1:0]           grant, grant_d, rr_ptr, rr_ptr_d, pick;
  logic                 found, fire, done, timeout;
  logic                 g_valid, g_ready, g_last;
  logic [ID_BITS-1:0]   g_id;
  logic [DATA_BITS-1:0] g_data;
  logic [1:0]           g_resp;
  logic [3:0]           valid_v;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign valid_v = {1'b0, bus.RVALID_S2, bus.RVALID_S1, bus.RVALID_S0};

  // grant is NONE whenever the FSM is IDLE, so the mux alone keeps the outputs at zero there
  always_comb begin
    g_valid = 1'b0;
    g_ready = 1'b0;
    g_last  = 1'b0;
    g_id    = '0;
    g_data  = '0;
    g_resp  = '0;
    case (grant)
      2'd0: begin
        g_valid = bus.RVALID_S0; g_ready = bus.RREADY_S0; g_last = bus.RLAST_S0;
        g_id    = bus.RID_S0;    g_data  = bus.RDATA_S0;  g_resp = bus.RRESP_S0;
      end
      2'd1: begin
        g_valid = bus.RVALID_S1; g_ready = bus.RREADY_S1; g_last = bus.RLAST_S1;
        g_id    = bus.RID_S1;    g_data  = bus.RDATA_S1;  g_resp = bus.RRESP_S1;
      end
      2'd2: begin
        g_valid = bus.RVALID_S2; g_ready = bus.RREADY_S2; g_last = bus.RLAST_S2;
        g_id    = bus.RID_S2;    g_data  = bus.RDATA_S2;  g_resp = bus.RRESP_S2;
      end
      default: ;
    endcase
  end

  assign fire = g_valid & g_ready;
  assign done = (fire & g_last) | timeout;

  // Round-robin search starting at rr_ptr
  always_comb begin
    logic [1:0] cand;
    found = 1'b0;
    pick  = rr_ptr;
    cand  = rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!found && valid_v[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = inc3(cand);
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    rr_ptr_d = rr_ptr;
    case (state)
      IDLE: if (found) begin
        state_d = BUSY;
        grant_d = pick;
      end
      BUSY: if (done) begin
        state_d  = IDLE;
        grant_d  = NONE;
        rr_ptr_d = inc3(grant);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      grant  <= NONE;
      rr_ptr <= 2'd0;
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      rr_ptr <= rr_ptr_d;
    end
  end

`ifdef R_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  assign timeout = (state == BUSY) && !fire && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state != BUSY || fire || timeout) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign bus.ARB_TIMEOUT = timeout;
`else
  assign timeout = 1'b0;
`endif

  assign bus.SlaveID = grant;
  assign bus.RID     = g_id;
  assign bus.RDATA   = g_data;
  assign bus.RRESP   = g_resp;
  assign bus.RLAST   = g_last;
  assign bus.RVALID  = g_valid;

  assign dbg_busy   = (state == BUSY);
  assign dbg_rr_ptr = rr_ptr;
endmodule
